// File: rtl/mem_stream_pkg.sv
// Shared definitions for the memory read streamer: FSM state encoding and
// default width constants.
package mem_stream_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stream_skid.sv
// Two-entry first-word-fall-through buffer with valid/ready on both sides.
// The head entry drives the output directly, so a stalled beat holds steady.
module mem_stream_skid #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    logic [1:0]       count;
    logic [1:0]       count_nxt;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] head_nxt;
    logic [WIDTH-1:0] tail;
    logic [WIDTH-1:0] tail_nxt;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign level     = count;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_nxt = count;
        head_nxt  = head;
        tail_nxt  = tail;
        unique case ({push, pop})
            2'b10: begin
                if (count == 2'd0) head_nxt = in_data;
                else               tail_nxt = in_data;
                count_nxt = count + 2'd1;
            end
            2'b01: begin
                head_nxt  = tail;
                count_nxt = count - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop: the new word lands behind whatever stays.
                if (count == 2'd1) begin
                    head_nxt = in_data;
                end else begin
                    head_nxt = tail;
                    tail_nxt = in_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= 2'd0;
        else     count <= count_nxt;
    end

    always_ff @(posedge clk) begin
        head <= head_nxt;
        tail <= tail_nxt;
    end

endmodule

// File: rtl/mem_read_streamer.sv
// Streams a burst of words from a 1-cycle-latency memory to a valid/ready port.
// Optional beat counter enabled by defining MEM_READ_STREAMER_PERF_EN.
module mem_read_streamer
    import mem_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  start_len,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
`ifdef MEM_READ_STREAMER_PERF_EN
    ,
    output logic [31:0]           beat_count
`endif
);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  rd_pending;
    logic                  rd_last_pending;
    logic                  zero_done;
    logic                  accept;
    logic                  pop;
    logic                  burst_done;
    logic                  last_issue;
    logic [1:0]            level;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH:0]   buf_out;
    logic                  buf_unused_ready;

    // Credit excludes the beat leaving this cycle so a full-rate stream never bubbles.
    assign occupancy  = {1'b0, level} + {2'b00, rd_pending} - {2'b00, pop};
    assign pop        = out_valid & out_ready;
    assign last_issue = (remaining == LEN_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_ready = (state == IDLE);
        accept      = start_valid & (state == IDLE);
        mem_rd_en   = 1'b0;
        burst_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && (start_len != '0)) state_nxt = READ;
            end
            READ: begin
                mem_rd_en = (occupancy < 3'd2);
                if (mem_rd_en && last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && buf_out[DATA_WIDTH]) begin
                    state_nxt  = IDLE;
                    burst_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr            <= '0;
            remaining       <= '0;
            rd_pending      <= 1'b0;
            rd_last_pending <= 1'b0;
            zero_done       <= 1'b0;
        end else begin
            zero_done       <= accept && (start_len == '0);
            rd_pending      <= mem_rd_en;
            rd_last_pending <= mem_rd_en && last_issue;
            if (accept) begin
                addr      <= start_addr;
                remaining <= start_len;
            end else if (mem_rd_en) begin
                addr      <= addr + ADDR_WIDTH'(1);
                remaining <= remaining - LEN_WIDTH'(1);
            end
        end
    end

    // Returning data is only captured for reads issued since the last reset.
    mem_stream_skid #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_pending),
        .in_ready  (buf_unused_ready),
        .in_data   ({rd_last_pending, mem_rd_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out),
        .level     (level)
    );

    assign mem_addr = addr;
    assign out_data = buf_out[DATA_WIDTH-1:0];
    assign out_last = buf_out[DATA_WIDTH] & out_valid;
    assign busy     = (state != IDLE);
    assign done     = zero_done | burst_done;

`ifdef MEM_READ_STREAMER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            beat_count <= '0;
        else if (pop && (beat_count != '1)) beat_count <= beat_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_read_streamer.sv
// Directed self-checking bench for mem_read_streamer with a 1-cycle memory model.
// Define MEM_READ_STREAMER_PERF_EN to also exercise the beat counter.
module tb_mem_read_streamer;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [AW-1:0] start_addr;
    logic [LW-1:0] start_len;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef MEM_READ_STREAMER_PERF_EN
    logic [31:0]   beat_count;
`endif

    always #5 clk = ~clk;

    mem_read_streamer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_addr  (start_addr),
        .start_len   (start_len),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
`ifdef MEM_READ_STREAMER_PERF_EN
        ,
        .beat_count  (beat_count)
`endif
    );

    function automatic logic [31:0] word(input logic [AW-1:0] a);
        return {16'hC0DE, 6'd0, a};
    endfunction

    always @(posedge clk) mem_rd_data <= mem_rd_en ? word(mem_addr) : 32'hDEADBEEF;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [AW-1:0] rd_q[$];
    logic [DW:0]   beat_q[$];
    int            done_cnt;
    int            issued;
    int            accepted;
    int            max_out;
    logic          prev_stall;
    logic [DW:0]   prev_beat;

    initial begin
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_beat", 64'({out_last, out_data}), 64'(prev_beat));
                end
                if (mem_rd_en) begin
                    rd_q.push_back(mem_addr);
                    issued++;
                end
                if (out_valid && out_ready) begin
                    beat_q.push_back({out_last, out_data});
                    accepted++;
                end
                if (done) done_cnt++;
                if (issued - accepted > max_out) max_out = issued - accepted;
                prev_stall = out_valid && !out_ready;
                prev_beat  = {out_last, out_data};
            end
        end
    end

    task automatic clear_mon();
        rd_q.delete();
        beat_q.delete();
        done_cnt = 0;
        issued   = 0;
        accepted = 0;
        max_out  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [AW-1:0] a, input logic [LW-1:0] l);
        start_valid = 1'b1;
        start_addr  = a;
        start_len   = l;
        tick();
        start_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit stall, input string tag);
        logic [15:0] pat;
        bit ok;
        pat = 16'b0110_1001_1101_0010;
        ok  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (stall) out_ready = pat[c % 16];
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_finish"}, 64'(ok), 64'd1);
    endtask

    task automatic check_beats(input string tag, input logic [AW-1:0] base, input int len);
        logic [AW-1:0] ea;
        logic          lst;
        check({tag, "_beats"}, 64'(beat_q.size()), 64'(len));
        if (beat_q.size() == len) begin
            for (int i = 0; i < len; i++) begin
                ea  = base + AW'(i);
                lst = (i == len - 1);
                check({tag, "_beat"}, 64'(beat_q[i]), 64'({lst, word(ea)}));
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        bit reached;
        rst         = 1'b1;
        start_valid = 1'b0;
        start_addr  = '0;
        start_len   = '0;
        out_ready   = 1'b1;
        clear_mon();
        tick();
        tick();
        check("rst_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();
        check("rel_start_ready", 64'(start_ready), 64'd1);

        // Basic full-rate burst, cycle-exact
        clear_mon();
        start_burst(10'h010, 11'd4);
        check("b1_rd_en", 64'(mem_rd_en), 64'd1);
        check("b1_addr", 64'(mem_addr), 64'h010);
        check("b1_busy", 64'(busy), 64'd1);
        check("b1_start_ready", 64'(start_ready), 64'd0);
        tick();
        check("b1_no_early_beat", 64'(out_valid), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("b1_valid", 64'(out_valid), 64'd1);
            check("b1_data", 64'(out_data), 64'(word(AW'(10'h010 + i))));
            check("b1_last", 64'(out_last), 64'(i == 3));
            check("b1_done", 64'(done), 64'(i == 3));
            tick();
        end
        check("b1_idle_busy", 64'(busy), 64'd0);
        check("b1_idle_done", 64'(done), 64'd0);
        check("b1_idle_valid", 64'(out_valid), 64'd0);
        check("b1_done_cnt", 64'(done_cnt), 64'd1);
        check("b1_reads", 64'(rd_q.size()), 64'd4);

        // Address wrap
        clear_mon();
        start_burst(10'h3FE, 11'd4);
        wait_idle(1'b0, "wrap");
        check("wrap_reads", 64'(rd_q.size()), 64'd4);
        if (rd_q.size() == 4) begin
            check("wrap_a0", 64'(rd_q[0]), 64'h3FE);
            check("wrap_a1", 64'(rd_q[1]), 64'h3FF);
            check("wrap_a2", 64'(rd_q[2]), 64'h000);
            check("wrap_a3", 64'(rd_q[3]), 64'h001);
        end
        check_beats("wrap", 10'h3FE, 4);

        // Zero-length request
        clear_mon();
        start_burst(10'h055, 11'd0);
        check("z_done", 64'(done), 64'd1);
        check("z_busy", 64'(busy), 64'd0);
        check("z_start_ready", 64'(start_ready), 64'd1);
        tick();
        check("z_done_gone", 64'(done), 64'd0);
        repeat (4) tick();
        check("z_reads", 64'(rd_q.size()), 64'd0);
        check("z_beats", 64'(beat_q.size()), 64'd0);
        check("z_done_cnt", 64'(done_cnt), 64'd1);

        // Backpressure with a fixed stall pattern
        clear_mon();
        start_burst(10'h040, 11'd8);
        wait_idle(1'b1, "stall");
        check_beats("stall", 10'h040, 8);
        check("stall_outstanding_le2", 64'(max_out <= 2), 64'd1);
        check("stall_done_cnt", 64'(done_cnt), 64'd1);

        // Ignored start while busy
        clear_mon();
        start_burst(10'h080, 11'd2);
        start_valid = 1'b1;
        start_addr  = 10'h0F0;
        start_len   = 11'd5;
        check("busy_start_ready", 64'(start_ready), 64'd0);
        tick();
        start_valid = 1'b0;
        wait_idle(1'b0, "busy_start");
        check_beats("busy_start", 10'h080, 2);

        // Reset in the middle of a burst
        clear_mon();
        start_burst(10'h100, 11'd8);
        reached = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (beat_q.size() >= 3) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        check("mid_reached", 64'(reached), 64'd1);
        check("mid_three_beats", 64'(beat_q.size()), 64'd3);
        rst = 1'b1;
        #1;
        check("mid_rd_en", 64'(mem_rd_en), 64'd0);
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_out_last", 64'(out_last), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_done", 64'(done), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("mid_no_more_beats", 64'(beat_q.size()), 64'd3);
        check("mid_no_done", 64'(done_cnt), 64'd0);
        check("mid_start_ready", 64'(start_ready), 64'd1);
        clear_mon();
        start_burst(10'h020, 11'd2);
        wait_idle(1'b0, "after_rst");
        check_beats("after_rst", 10'h020, 2);
        check("after_rst_done_cnt", 64'(done_cnt), 64'd1);

`ifdef MEM_READ_STREAMER_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("perf_cleared", 64'(beat_count), 64'd0);
        start_burst(10'h200, 11'd5);
        wait_idle(1'b0, "perf_a");
        start_burst(10'h300, 11'd3);
        wait_idle(1'b0, "perf_b");
        check("perf_count", 64'(beat_count), 64'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
